// File: rtl/uart_rx_baud_ctrl.sv
// Baud configuration controller and one-deep byte buffer for uart_rx.
// Autobaud (0x55 sync measurement) is built only when UART_RX_AUTOBAUD_EN is defined.
module uart_rx_baud_ctrl #(
    parameter logic [15:0] DEF_BIT_DUR  = 16'd433,
    parameter logic [1:0]  DEF_STOPBITS = 2'b01,
    parameter logic [15:0] AB_MIN       = 16'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        cfg_we,
    input  logic [15:0] cfg_bit_duration,
    input  logic [1:0]  cfg_stopbits,
    input  logic        ab_start,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_ready,
    output logic [15:0] bit_duration,
    output logic [15:0] start_bit_duration,
    output logic [1:0]  stopbits,
    output logic        rx_rst,
    output logic        busy,
    output logic        locked,
    output logic        ab_error,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        overrun
);

    logic [15:0] bit_dur_q, bit_dur_d;
    logic [1:0]  stopbits_q, stopbits_d;
    logic        locked_q, locked_d;
    logic        ab_error_q, ab_error_d;
    logic        overrun_q, overrun_d;
    logic        cfg_pulse_q, cfg_pulse_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        cap_en;

`ifdef UART_RX_AUTOBAUD_EN
    typedef enum logic [2:0] {
        StIdle, StAbWaitHigh, StAbWaitEdge, StAbMeasure, StAbWaitStop
    } state_e;

    state_e      state_q, state_d;
    logic        rx_meta_q, rxs_q, rxs_prev_q;
    logic [18:0] cnt_q, cnt_d, cnt_plus;
    logic [1:0]  edges_q, edges_d;
    logic        seen_q, seen_d;
    logic        fall, rise, stop_done;
    logic [15:0] meas;

    assign fall      = rxs_prev_q & ~rxs_q;
    assign rise      = ~rxs_prev_q & rxs_q;
    assign cnt_plus  = cnt_q + 19'd1;
    assign meas      = cnt_plus[18:3];
    assign stop_done = (state_q == StAbWaitStop) && seen_q && rxs_q &&
                       (cnt_q == {3'b000, bit_dur_q});
    assign busy      = (state_q != StIdle);
    // Release uart_rx in the very cycle the stop-bit timer expires.
    assign rx_rst    = cfg_pulse_q | (busy & ~stop_done);
    assign ab_error  = ab_error_q;
    assign cap_en    = (state_q == StIdle) && !rx_rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            cnt_q      <= '0;
            edges_q    <= '0;
            seen_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
            cnt_q      <= cnt_d;
            edges_q    <= edges_d;
            seen_q     <= seen_d;
        end
    end
`else
    logic unused_ab;
    assign unused_ab = ^{rx, ab_start};
    assign busy      = 1'b0;
    assign ab_error  = 1'b0;
    assign rx_rst    = cfg_pulse_q;
    assign cap_en    = !rx_rst;
`endif

    always_comb begin
        bit_dur_d   = bit_dur_q;
        stopbits_d  = stopbits_q;
        locked_d    = locked_q;
        ab_error_d  = ab_error_q;
        overrun_d   = overrun_q;
        cfg_pulse_d = 1'b0;
        data_d      = data_q;
        valid_d     = valid_q;
`ifdef UART_RX_AUTOBAUD_EN
        state_d     = state_q;
        cnt_d       = cnt_q;
        edges_d     = edges_q;
        seen_d      = seen_q;

        unique case (state_q)
            StIdle: begin
                if (ab_start) begin
                    state_d    = StAbWaitHigh;
                    ab_error_d = 1'b0;
                    overrun_d  = 1'b0;
                end
            end
            StAbWaitHigh: begin
                if (rxs_q) state_d = StAbWaitEdge;
            end
            StAbWaitEdge: begin
                if (fall) begin
                    cnt_d   = '0;
                    edges_d = '0;
                    state_d = StAbMeasure;
                end
            end
            StAbMeasure: begin
                cnt_d = cnt_plus;
                if (cnt_q == '1) begin
                    ab_error_d = 1'b1;
                    state_d    = StIdle;
                end else if (fall && edges_q == 2'd3) begin
                    // cnt_plus includes this edge cycle: eight full bit times.
                    if (meas < AB_MIN + 16'd1) begin
                        ab_error_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        bit_dur_d = meas - 16'd1;
                        locked_d  = 1'b1;
                        seen_d    = 1'b0;
                        state_d   = StAbWaitStop;
                    end
                end else if (fall) begin
                    edges_d = edges_q + 2'd1;
                end
            end
            StAbWaitStop: begin
                if (rise) begin
                    cnt_d  = 19'd1;
                    seen_d = 1'b1;
                end else if (seen_q) begin
                    if (fall) begin
                        ab_error_d = 1'b1;
                        state_d    = StIdle;
                    end else if (stop_done) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_plus;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
`endif

        if (cfg_we) begin
            bit_dur_d   = cfg_bit_duration;
            stopbits_d  = cfg_stopbits;
            locked_d    = 1'b1;
            ab_error_d  = 1'b0;
            overrun_d   = 1'b0;
            cfg_pulse_d = 1'b1;
`ifdef UART_RX_AUTOBAUD_EN
            state_d     = StIdle;
`endif
        end

        if (valid_q && byte_ready) valid_d = 1'b0;
        if (cap_en && rx_data_ready) begin
            if (!valid_q || byte_ready) begin
                data_d  = rx_data;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_dur_q   <= DEF_BIT_DUR;
            stopbits_q  <= DEF_STOPBITS;
            locked_q    <= 1'b0;
            ab_error_q  <= 1'b0;
            overrun_q   <= 1'b0;
            cfg_pulse_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            bit_dur_q   <= bit_dur_d;
            stopbits_q  <= stopbits_d;
            locked_q    <= locked_d;
            ab_error_q  <= ab_error_d;
            overrun_q   <= overrun_d;
            cfg_pulse_q <= cfg_pulse_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

    assign bit_duration       = bit_dur_q;
    assign start_bit_duration = {1'b0, bit_dur_q[15:1]};
    assign stopbits           = stopbits_q;
    assign locked             = locked_q;
    assign overrun            = overrun_q;
    assign byte_data          = data_q;
    assign byte_valid         = valid_q;

endmodule
